// File: rtl/regfile_demux32.sv
// regfile_demux32: 32 x 32-bit MIPS general-purpose register file.
// One byte-lane-masked write port decoded onto registers 1..31, two
// combinational read ports, $0 hardwired to zero, optional write-through
// bypass, and a free-running count of committed writes.
//
// Port protocol: there is no handshake. Every rising edge with resetn=1
// and we=1 is one committed write, with no back-pressure. Reads are pure
// combinational functions of raddr, the stored state and, with BYPASS=1,
// the write port in the current cycle.
module regfile_demux32 #(
  parameter bit          BYPASS    = 1'b1,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [3:0]  wbe,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic [7:0]  wr_cnt
);

  // Per-bit form of the byte-lane enables.
  logic [31:0] w_lane_mask;
  // One-hot write strobes; bit 0 exists only so the vector lines up with
  // register numbers and is tied low.
  logic [31:0] w_strobe;
  // Stored view of every register number, with entry 0 tied to zero.
  logic [31:0] w_stored [0:31];
  // Stored value of the destination merged with the incoming lanes.
  logic [31:0] w_merged;
  logic        w_byp1;
  logic        w_byp2;

  logic [31:0] r_regs [1:31];
  logic [7:0]  r_wr_cnt;

  assign w_lane_mask = {{8{wbe[3]}}, {8{wbe[2]}}, {8{wbe[1]}}, {8{wbe[0]}}};

  // Write decode: strobe register k when enabled and addressed, never $0.
  always_comb begin
    w_strobe = '0;
    for (int k = 1; k < 32; k++) begin
      w_strobe[k] = we && (waddr == 5'(k));
    end
  end

  assign w_stored[0] = 32'h0000_0000;

  genvar g;
  generate
    for (g = 1; g < 32; g++) begin : g_reg
      assign w_stored[g] = r_regs[g];

      // Storage for register g: reset to RESET_VAL, lane-merged on strobe.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_regs[g] <= RESET_VAL;
        end else if (w_strobe[g]) begin
          r_regs[g] <= (r_regs[g] & ~w_lane_mask) | (wdata & w_lane_mask);
        end
      end
    end
  endgenerate

  // Value the destination register will hold after this edge's write.
  assign w_merged = (w_stored[waddr] & ~w_lane_mask) | (wdata & w_lane_mask);

  // Bypass qualifies only for a live write to a real register.
  assign w_byp1 = BYPASS && we && (raddr1 == waddr) && (waddr != 5'd0);
  assign w_byp2 = BYPASS && we && (raddr2 == waddr) && (waddr != 5'd0);

  // Read port 1: stored value, or the merged lanes when bypassing.
  always_comb begin
    rdata1 = w_stored[raddr1];
    if (w_byp1) begin
      rdata1 = w_merged;
    end
  end

  // Read port 2: same selection, independent of port 1.
  always_comb begin
    rdata2 = w_stored[raddr2];
    if (w_byp2) begin
      rdata2 = w_merged;
    end
  end

  // Committed-write counter; counts writes to $0 and empty-mask writes too.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_cnt <= 8'h00;
    end else if (we) begin
      r_wr_cnt <= r_wr_cnt + 8'd1;
    end
  end

  assign wr_cnt = r_wr_cnt;

endmodule

// File: tb/tb_regfile_demux32.sv
// Self-checking bench for regfile_demux32. Two instances share every
// input: one with the write-through bypass, one without. A behavioural
// model (plain array plus counter) predicts both read ports and the write
// counter, and a compare process checks them every cycle. Directed
// sections add hand-computed literal expectations.
module tb_regfile_demux32;

  logic        clk;
  logic        resetn;
  logic        we;
  logic [4:0]  waddr;
  logic [3:0]  wbe;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1_b, rdata2_b, rdata1_n, rdata2_n;
  logic [7:0]  wr_cnt_b, wr_cnt_n;

  int n_vec;
  int n_fail;
  bit chk_en;

  // Behavioural model: register contents and committed-write count.
  logic [31:0] m_regs [0:31];
  int          m_cnt;
  logic [31:0] exp_q [$];

  regfile_demux32 #(.BYPASS(1'b1), .RESET_VAL(32'h0)) u_dut_byp (
    .clk(clk), .resetn(resetn), .we(we), .waddr(waddr), .wbe(wbe),
    .wdata(wdata), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1_b), .rdata2(rdata2_b), .wr_cnt(wr_cnt_b)
  );

  regfile_demux32 #(.BYPASS(1'b0), .RESET_VAL(32'h0)) u_dut_nob (
    .clk(clk), .resetn(resetn), .we(we), .waddr(waddr), .wbe(wbe),
    .wdata(wdata), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1_n), .rdata2(rdata2_n), .wr_cnt(wr_cnt_n)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
    m_cnt = 0;
  endtask

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] v;
    v = old_v;
    for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = new_v[8*i +: 8];
    return v;
  endfunction

  // Model commit: one write per edge while out of reset.
  always @(posedge clk) begin
    if (resetn === 1'b1 && we === 1'b1) begin
      m_cnt = (m_cnt + 1) % 256;
      if (waddr != 5'd0) m_regs[waddr] = lane_merge(m_regs[waddr], wdata, wbe);
    end
  end

  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && we && a == waddr) return lane_merge(m_regs[a], wdata, wbe);
    return m_regs[a];
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard compare process: mid-low-phase, after inputs have settled.
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      cmp("rd1_byp", rdata1_b, exp_read(raddr1, 1'b1));
      cmp("rd2_byp", rdata2_b, exp_read(raddr2, 1'b1));
      cmp("rd1_nob", rdata1_n, exp_read(raddr1, 1'b0));
      cmp("rd2_nob", rdata2_n, exp_read(raddr2, 1'b0));
      cmp("cnt_byp", {24'h0, wr_cnt_b}, 32'(m_cnt));
      cmp("cnt_nob", {24'h0, wr_cnt_n}, 32'(m_cnt));
    end
  end

  // Driver tasks: inputs change on the falling edge only.
  task automatic drive(input logic w, input logic [4:0] wa, input logic [3:0] be,
                       input logic [31:0] d, input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    we = w; waddr = wa; wbe = be; wdata = d; raddr1 = r1; raddr2 = r2;
  endtask

  task automatic idle_read(input logic [4:0] r1, input logic [4:0] r2);
    drive(1'b0, 5'd0, 4'h0, 32'h0, r1, r2);
  endtask

  // Literal check between edges on the current inputs.
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp(name, act, exp);
  endtask

  initial begin
    n_vec = 0; n_fail = 0; chk_en = 1'b0;
    resetn = 1'b0; we = 1'b0; waddr = '0; wbe = '0; wdata = '0;
    raddr1 = '0; raddr2 = '0;
    model_reset();
    #1 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Reset state on all addresses
    for (int k = 0; k < 32; k++) begin
      idle_read(5'(k), 5'(31 - k));
      #3 lit("rst_rd1", rdata1_b, 32'h0);
    end
    lit("rst_cnt", {24'h0, wr_cnt_b}, 32'h0);

    // Full write / readback, then $0 write
    for (int k = 1; k < 32; k++) drive(1'b1, 5'(k), 4'hF, 32'hA5A5_0000 | k, 5'd0, 5'd0);
    drive(1'b1, 5'd0, 4'hF, 32'hFFFF_FFFF, 5'd0, 5'd0);
    for (int k = 0; k < 32; k++) begin
      idle_read(5'(k), 5'(k));
      #3;
      exp_q.push_back(k == 0 ? 32'h0 : (32'hA5A5_0000 | k));
      lit("full_rd1", rdata1_n, exp_q[0]);
      lit("full_rd2", rdata2_b, exp_q.pop_front());
    end
    lit("cnt32", {24'h0, wr_cnt_n}, 32'd32);

    // Byte lanes
    drive(1'b1, 5'd5, 4'hF, 32'h1122_3344, 5'd5, 5'd0);
    drive(1'b1, 5'd5, 4'b0101, 32'hAABB_CCDD, 5'd5, 5'd0);
    idle_read(5'd5, 5'd5);
    #3 lit("lane_0101", rdata1_n, 32'h11BB_33DD);
    drive(1'b1, 5'd5, 4'b0000, 32'hFFFF_FFFF, 5'd5, 5'd5);
    #3 lit("lane_be0_byp", rdata1_b, 32'h11BB_33DD);
    idle_read(5'd5, 5'd5);
    #3 lit("lane_be0", rdata2_n, 32'h11BB_33DD);
    lit("cnt35", {24'h0, wr_cnt_b}, 32'd35);

    // Bypass on both ports in the write cycle
    drive(1'b1, 5'd7, 4'hF, 32'h0, 5'd0, 5'd0);
    drive(1'b1, 5'd7, 4'b0011, 32'hDEAD_BEEF, 5'd7, 5'd7);
    #3;
    lit("byp_rd1", rdata1_b, 32'h0000_BEEF);
    lit("byp_rd2", rdata2_b, 32'h0000_BEEF);
    lit("nob_rd1", rdata1_n, 32'h0);
    drive(1'b1, 5'd0, 4'hF, 32'hFFFF_FFFF, 5'd0, 5'd0);
    #3 lit("byp_zero", rdata1_b, 32'h0);
    idle_read(5'd7, 5'd7);
    #3 lit("nob_after", rdata1_n, 32'h0000_BEEF);

    // Reset asserted mid-write
    drive(1'b1, 5'd3, 4'hF, 32'h1234_5678, 5'd3, 5'd0);
    drive(1'b1, 5'd3, 4'hF, 32'hFFFF_FFFF, 5'd3, 5'd3);
    #4 resetn = 1'b0;
    model_reset();
    #1;
    lit("mid_cnt", {24'h0, wr_cnt_b}, 32'h0);
    lit("mid_nob", rdata1_n, 32'h0);
    lit("mid_byp", rdata1_b, 32'hFFFF_FFFF);
    @(negedge clk);
    we = 1'b0; resetn = 1'b1;
    #3;
    lit("mid_reg3", rdata1_b, 32'h0);
    lit("mid_cnt2", {24'h0, wr_cnt_n}, 32'h0);

    // 256 random writes wrap the counter
    for (int n = 0; n < 256; n++)
      drive(1'b1, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    idle_read(5'd1, 5'd2);
    #3 lit("wrap", {24'h0, wr_cnt_b}, 32'h0);

    // Random mixed traffic with frequent read/write address collisions
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), wa, 4'($urandom_range(0, 15)), $urandom,
            ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)));
    end
    idle_read(5'd0, 5'd0);
    @(negedge clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_demux32.md
# regfile_demux32

General-purpose register file for the MIPS datapath: one write port that decodes (demultiplexes) a 5-bit destination and byte-lane mask into 32 x 32-bit registers, plus two combinational read ports. It is the write-side counterpart of the datapath operand selectors. Write-back drives it, and decode reads rs/rt from it. Register $0 is hardwired to zero. An optional write-through bypass hides same-cycle write/read hazards.

## Interface
- BYPASS, 1, 1 = a read of the register being written this cycle returns the new lane data; 0 = it returns the stored value.
- RESET_VAL, 32'h0000_0000, value loaded into registers 1..31 on reset.
- clk  input  1  rising-edge clock; the only clock.
- resetn  input  1  asynchronous, active-low reset.
- we  input  1  write enable.
- waddr  input  5  destination register number.
- wbe  input  4  byte-lane enables; wbe[i] covers bits [8i+7:8i].
- wdata  input  32  write data.
- raddr1  input  5  read port 1 register number (rs).
- raddr2  input  5  read port 2 register number (rt).
- rdata1  output  32  read port 1 data.
- rdata2  output  32  read port 2 data.
- wr_cnt  output  8  count of committed writes, wraps modulo 256. Used for debug and coverage.

## Operation
- Storage is registers 1..31, 32 bits each. Register 0 has no storage and always reads 32'h0.
- Write decode: the write strobe for register k is we & (waddr==k) & (k!=0). Exactly one register or none is strobed per cycle.
- Lane merge: on a strobed register, bits of lane i take wdata lane i when wbe[i]=1. Other lanes hold.
- A write with we=1 and wbe=4'b0000 changes no register, but it still increments wr_cnt.
- A write to waddr=0 is accepted and discarded. wr_cnt increments, and reads of $0 remain 0.
- Read ports are purely combinational on raddr and stored state.
- Bypass (BYPASS=1): when we=1, raddrN==waddr and waddr!=0, then rdataN lane i = wdata lane i if wbe[i], otherwise the stored lane. Both ports bypass independently; raddr1==raddr2 is legal.
- Bypass never applies to $0.
- wr_cnt increments by 1 on every clock edge with we=1, and wraps from 8'hFF to 8'h00.

## Timing
- Reset: asserting resetn=0 immediately and asynchronously sets registers 1..31 to RESET_VAL and wr_cnt to 0.
- During reset, rdata1/rdata2 show RESET_VAL, or 0 for $0. With BYPASS=1 and we=1 during reset, rdata shows the bypassed lanes, but no write is committed.
- Writes are ignored while resetn=0.
- Reset release is synchronous to use: the first write is committed on the first rising edge with resetn=1.
- Write latency: data is committed at the rising edge where we=1, and is visible on the read ports after that edge (zero-cycle visibility with BYPASS=1).
- Read latency: combinational, zero cycles. Output settles within the same cycle as the raddr change.
- Reset asserted mid-write: the reset wins, and that edge's write is lost.
- Back-to-back writes to the same register on consecutive cycles: each commits in order, and the last one wins.
- There are no stalls and no handshake. The block accepts one write per cycle, unconditionally.

## Test plan
- Reset: resetn=0 with RESET_VAL=0, then release. Read all 32 addresses -> every rdata1/rdata2 = 32'h0 and wr_cnt = 0.
- Full write/readback: write reg k with 32'hA5A5_0000|k for k=1..31 using wbe=4'hF. Read back on both ports -> exact values. Write $0 with 32'hFFFF_FFFF -> reads 0. Then wr_cnt = 32.
- Byte lanes: reg 5 = 32'h1122_3344. Write 32'hAABB_CCDD with wbe=4'b0101 -> reg 5 = 32'h11BB_33DD. Write with wbe=0 -> unchanged, wr_cnt still increments.
- Bypass (BYPASS=1): reg 7 = 32'h0000_0000. In one cycle set we=1, waddr=7, wdata=32'hDEAD_BEEF, wbe=4'b0011, raddr1=raddr2=7 -> both rdata = 32'h0000_BEEF in the same cycle. With BYPASS=0 -> 32'h0 until after the edge.
- Reset mid-operation: write reg 3 = 32'h1234_5678. Assert resetn low asynchronously between edges, in the same cycle as a write of 32'hFFFF_FFFF to reg 3 -> reg 3 = RESET_VAL, the write is lost and wr_cnt = 0.
- Counter wrap: issue 256 writes -> wr_cnt returns to 8'h00. Random write/read traffic checked against a reference model -> no mismatches.
